// File: rtl/droute_cfg_seq_if.sv
// Port bundle of the data_route configuration sequencer: table writes, run control,
// the monitored stream handshake and the switch words driven toward data_route.
interface droute_cfg_seq_if #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  cfg_wr_en;
    logic [ADDR_W-1:0]     cfg_wr_addr;
    logic [36+CNT_W-1:0]   cfg_wr_data;
    logic [ADDR_W:0]       num_phases;
    logic                  start;
    logic                  abort;
    logic                  mon_tvalid;
    logic                  mon_tready;
    logic [17:0]           m_droute_switch_0;
    logic [17:0]           m_droute_switch_1;
    logic                  m_droute_switch_valid;
    logic                  busy;
    logic                  done;
    logic [ADDR_W-1:0]     phase;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, num_phases, start, abort,
               mon_tvalid, mon_tready,
        input  m_droute_switch_0, m_droute_switch_1, m_droute_switch_valid,
               busy, done, phase
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, num_phases, start, abort,
               mon_tvalid, mon_tready,
        output m_droute_switch_0, m_droute_switch_1, m_droute_switch_valid,
               busy, done, phase
    );
endinterface

// File: rtl/droute_cfg_seq.sv
// Phase-table sequencer for data_route: issues each phase's two switch words, then
// waits for the phase's beat count on the monitored stream before moving on.
module droute_cfg_seq #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input logic             clk,
    input logic             rst_n,
    droute_cfg_seq_if.slave bus
);
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int ENTRY_W = 36 + CNT_W;
    localparam logic [ADDR_W:0] DEPTH_V = DEPTH[ADDR_W:0];

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_RUN   = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t              state_r;
    logic [ENTRY_W-1:0]  mem_r [DEPTH];
    logic [ENTRY_W-1:0]  entry_r;
    logic [ADDR_W:0]     num_lat_r;
    logic [ADDR_W-1:0]   phase_r;
    logic [CNT_W-1:0]    beat_cnt_r;
    logic                valid_r;
    logic                done_r;

    logic                hs_s;
    logic                busy_s;
    logic [CNT_W:0]      beat_inc_s;
    logic [ADDR_W:0]     phase_inc_s;
    logic [ADDR_W:0]     num_clamp_s;
    logic [CNT_W-1:0]    target_s;

    // Handshake detect, busy decode, incrementers and phase-count clamp.
    always_comb begin
        hs_s        = bus.mon_tvalid & bus.mon_tready;
        busy_s      = (state_r != ST_IDLE);
        beat_inc_s  = {1'b0, beat_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        phase_inc_s = {1'b0, phase_r} + {{ADDR_W{1'b0}}, 1'b1};
        target_s    = entry_r[CNT_W-1:0];
        if (bus.num_phases > DEPTH_V) begin
            num_clamp_s = DEPTH_V;
        end else begin
            num_clamp_s = bus.num_phases;
        end
    end

    // Phase table storage; writes are only honoured while idle.
    always_ff @(posedge clk) begin
        if (bus.cfg_wr_en && !busy_s) begin
            mem_r[bus.cfg_wr_addr] <= bus.cfg_wr_data;
        end
    end

    // Sequencer FSM with registered valid/done pulses and entry (read) register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            entry_r    <= '0;
            num_lat_r  <= '0;
            phase_r    <= '0;
            beat_cnt_r <= '0;
            valid_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            if (bus.abort && busy_s) begin
                state_r    <= ST_IDLE;
                phase_r    <= '0;
                beat_cnt_r <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            num_lat_r  <= num_clamp_s;
                            phase_r    <= '0;
                            beat_cnt_r <= '0;
                            if (num_clamp_s == '0) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_LOAD;
                            end
                        end
                    end
                    ST_LOAD: begin
                        // The entry register doubles as the held switch-word output.
                        entry_r <= mem_r[phase_r];
                        valid_r <= 1'b1;
                        state_r <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        beat_cnt_r <= '0;
                        state_r    <= (target_s == '0) ? ST_NEXT : ST_RUN;
                    end
                    ST_RUN: begin
                        if (hs_s) begin
                            beat_cnt_r <= beat_inc_s[CNT_W-1:0];
                            if (beat_inc_s == {1'b0, target_s}) begin
                                state_r <= ST_NEXT;
                            end
                        end
                    end
                    ST_NEXT: begin
                        beat_cnt_r <= '0;
                        if (phase_inc_s == num_lat_r) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            phase_r <= phase_inc_s[ADDR_W-1:0];
                            state_r <= ST_LOAD;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.m_droute_switch_0     = entry_r[CNT_W +: 18];
    assign bus.m_droute_switch_1     = entry_r[CNT_W+18 +: 18];
    assign bus.m_droute_switch_valid = valid_r;
    assign bus.busy                  = busy_s;
    assign bus.done                  = done_r;
    assign bus.phase                 = phase_r;
endmodule

// File: tb/tb_droute_cfg_seq.sv
// Randomized bench for droute_cfg_seq: per-run expectations come from a trace model
// that schedules issue/next/done cycles from the pre-generated handshake pattern.
module tb_droute_cfg_seq;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int EW     = 36 + CNT_W;
    localparam int MAXC   = 600;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    droute_cfg_seq_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
    droute_cfg_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    logic [EW-1:0] tbl [DEPTH];
    logic [17:0]   last_sw0 = 18'h0;
    logic [17:0]   last_sw1 = 18'h0;
    bit            mv [MAXC];
    bit            mr [MAXC];
    bit            e_valid [MAXC];
    bit            e_done [MAXC];
    bit            e_busy [MAXC];
    int            e_phase [MAXC];
    int            iss [MAXC];
    logic [17:0]   e_sw0 [MAXC];
    logic [17:0]   e_sw1 [MAXC];
    int            run_len;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [17:0] s1, input logic [17:0] s0,
                                         input logic [CNT_W-1:0] n);
        return {s1, s0, n};
    endfunction

    task automatic wr(input int a, input logic [EW-1:0] d);
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = a[ADDR_W-1:0];
        bus.cfg_wr_data = d;
        @(posedge clk); #1;
        bus.cfg_wr_en   = 1'b0;
        tbl[a] = d;
    endtask

    // Schedule model: phase p issues at I; RUN counts handshakes from I+1 until the
    // beat count is met at t; NEXT at t+1; next issue at t+3 or done at t+2.
    task automatic build_model(input int nph, input int abort_at);
        int n, I, t, k, e, fin, cnt;
        logic [17:0] s0, s1;
        n = (nph > DEPTH) ? DEPTH : nph;
        I = 2;
        fin = 1;
        for (int p = 0; p < n; p++) begin
            cnt = int'(tbl[p][CNT_W-1:0]);
            for (int c = I - 1; c <= I; c++) begin
                e_busy[c] = 1'b1; e_phase[c] = p;
            end
            e_valid[I] = 1'b1;
            iss[I] = p;
            if (cnt == 0) begin
                e = I + 1;
            end else begin
                t = I; k = 0;
                while (k < cnt && t < MAXC - 8) begin
                    t++;
                    if (mv[t] && mr[t]) k++;
                end
                e = t + 1;
            end
            for (int c = I + 1; c <= e; c++) begin
                e_busy[c] = 1'b1; e_phase[c] = p;
            end
            if (p < n - 1) I = e + 2;
            else fin = e + 1;
        end
        e_busy[fin] = 1'b1; e_done[fin] = 1'b1; e_phase[fin] = n - 1;
        run_len = fin + 3;
        if (abort_at >= 0 && abort_at < fin) begin
            for (int c = abort_at + 1; c < MAXC; c++) begin
                e_valid[c] = 1'b0; e_done[c] = 1'b0; e_busy[c] = 1'b0;
                e_phase[c] = 0; iss[c] = -1;
            end
            run_len = abort_at + 4;
        end
        s0 = last_sw0; s1 = last_sw1;
        for (int c = 0; c < run_len; c++) begin
            if (iss[c] >= 0) begin
                s1 = tbl[iss[c]][EW-1 -: 18];
                s0 = tbl[iss[c]][CNT_W +: 18];
            end
            e_sw0[c] = s0; e_sw1[c] = s1;
        end
    endtask

    task automatic run(input string nm, input int nph, input int abort_at, input int mode,
                       input bit spur);
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                1: begin mv[c] = 1'b1; mr[c] = 1'b1; end
                2: begin mv[c] = 1'b1; mr[c] = (c % 2) == 1; end
                default: begin
                    mv[c] = ($urandom_range(3) != 0);
                    mr[c] = ($urandom_range(3) != 0);
                end
            endcase
            e_valid[c] = 1'b0; e_done[c] = 1'b0; e_busy[c] = 1'b0;
            e_phase[c] = -1; iss[c] = -1;
        end
        build_model(nph, abort_at);
        for (int c = 0; c < run_len; c++) begin
            bus.start       = (c == 0) || (spur && (c == 1 || c == 3));
            bus.num_phases  = nph[ADDR_W:0];
            bus.abort       = (c == abort_at);
            bus.mon_tvalid  = mv[c];
            bus.mon_tready  = mr[c];
            bus.cfg_wr_en   = spur && (c == 3);
            bus.cfg_wr_addr = '0;
            bus.cfg_wr_data = mk(18'($urandom()), 18'($urandom()), CNT_W'($urandom()));
            @(negedge clk);
            chk($sformatf("%s valid c%0d", nm, c), bus.m_droute_switch_valid, e_valid[c]);
            chk($sformatf("%s done c%0d", nm, c), bus.done, e_done[c]);
            chk($sformatf("%s busy c%0d", nm, c), bus.busy, e_busy[c]);
            chk($sformatf("%s sw0 c%0d", nm, c), bus.m_droute_switch_0, e_sw0[c]);
            chk($sformatf("%s sw1 c%0d", nm, c), bus.m_droute_switch_1, e_sw1[c]);
            if (e_phase[c] >= 0) chk($sformatf("%s phase c%0d", nm, c), bus.phase, e_phase[c]);
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_wr_en = 1'b0;
        bus.mon_tvalid = 1'b0; bus.mon_tready = 1'b0;
        last_sw0 = e_sw0[run_len-1];
        last_sw1 = e_sw1[run_len-1];
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, " valid"}, bus.m_droute_switch_valid, 1'b0);
        chk({nm, " done"}, bus.done, 1'b0);
        chk({nm, " busy"}, bus.busy, 1'b0);
        chk({nm, " sw0"}, bus.m_droute_switch_0, 18'h0);
        chk({nm, " sw1"}, bus.m_droute_switch_1, 18'h0);
        chk({nm, " phase"}, bus.phase, 0);
    endtask

    initial begin
        int n, dn, vl;
        bus.cfg_wr_en = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_data = '0;
        bus.num_phases = '0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.mon_tvalid = 1'b0; bus.mon_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        wr(0, mk(18'h2AAAA, 18'h15555, 16'd4));
        run("single", 1, -1, 1, 1'b0);

        wr(0, mk(18'h00A11, 18'h00B22, 16'd2));
        wr(1, mk(18'h01C33, 18'h01D44, 16'd0));
        wr(2, mk(18'h02E55, 18'h02F66, 16'd3));
        run("three", 3, -1, 2, 1'b1);
        run("rerun", 3, -1, 0, 1'b0);

        bus.num_phases = '0; bus.start = 1'b1; dn = 0; vl = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
            if (bus.m_droute_switch_valid) vl++;
            if (c == 1) chk("zero busy c1", bus.busy, 1'b1);
            if (c == 4) chk("zero busy c4", bus.busy, 1'b0);
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        chk("zero done count", dn, 1);
        chk("zero valid count", vl, 0);

        for (int p = 0; p < DEPTH; p++)
            wr(p, mk(18'($urandom()), 18'($urandom()), CNT_W'($urandom_range(0, 3))));
        run("clamp", DEPTH + 5, -1, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 6);
            for (int p = 0; p < n; p++)
                wr(p, mk(18'($urandom()), 18'($urandom()), CNT_W'($urandom_range(0, 5))));
            run($sformatf("rnd%0d", r), n, -1, 0, 1'($urandom_range(1)));
        end

        wr(0, mk(18'h11111, 18'h22222, 16'd3));
        wr(1, mk(18'h33333, 18'h04444, 16'd5));
        run("abort", 2, 10, 1, 1'b0);
        run("restart", 2, -1, 1, 1'b0);

        wr(0, mk(18'h3F00F, 18'h0F0F0, 16'd8));
        bus.num_phases = 5'd1; bus.start = 1'b1;
        bus.mon_tvalid = 1'b1; bus.mon_tready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("post reset valid c%0d", c), bus.m_droute_switch_valid, 1'b0);
            chk($sformatf("post reset busy c%0d", c), bus.busy, 1'b0);
            @(posedge clk); #1;
        end
        last_sw0 = 18'h0; last_sw1 = 18'h0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
